// File: rtl/fsm6_state_core.sv
// Register stage for the six-state A-F machine: holds y, applies the next-state
// rules on accepted w, recovers from illegal codes and counts entries into {E,F}.
//
// state | meaning
// ------+-----------------------------------------------
// A 000 | idle / restart
// B 001 | one 0 seen from A
// C 010 | two 0s seen
// D 011 | 1 seen after B/C/E/F
// E 100 | z=1, reached from C on 0, held on 0
// F 101 | z=1, reached from D on 0
// 110/111 | illegal, only reachable via load; recover to A
module fsm6_state_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             w_valid,
    input  logic             w,
    input  logic             load,
    input  logic [2:0]       load_state,
    output logic [2:0]       y,
    output logic             z,
    output logic             illegal,
    output logic [CNT_W-1:0] z_rises
);

    localparam logic [2:0] S_A = 3'b000;
    localparam logic [2:0] S_B = 3'b001;
    localparam logic [2:0] S_C = 3'b010;
    localparam logic [2:0] S_D = 3'b011;
    localparam logic [2:0] S_E = 3'b100;
    localparam logic [2:0] S_F = 3'b101;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       r_y;
    logic             r_illegal;
    logic [CNT_W-1:0] r_z_rises;

    logic [2:0]       w_fsm_next;
    logic [2:0]       w_y_next;
    logic             w_illegal_next;
    logic             w_y_bad;
    logic             w_rise;

    function automatic logic is_ef(input logic [2:0] s);
        return (s == S_E) || (s == S_F);
    endfunction

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_y       <= S_A;
            r_illegal <= 1'b0;
            r_z_rises <= '0;
        end else begin
            r_y       <= w_y_next;
            r_illegal <= w_illegal_next;
            if (w_rise && (r_z_rises != CNT_MAX)) begin
                r_z_rises <= r_z_rises + 1'b1;
            end
        end
    end

    always_comb begin
        w_fsm_next = S_A;
        case (r_y)
            S_A:     w_fsm_next = w ? S_A : S_B;
            S_B:     w_fsm_next = w ? S_D : S_C;
            S_C:     w_fsm_next = w ? S_D : S_E;
            S_D:     w_fsm_next = w ? S_A : S_F;
            S_E:     w_fsm_next = w ? S_D : S_E;
            S_F:     w_fsm_next = w ? S_D : S_C;
            default: w_fsm_next = S_A;
        endcase

        w_y_bad        = (r_y == 3'b110) || (r_y == 3'b111);
        w_y_next       = r_y;
        w_illegal_next = 1'b0;
        w_rise         = 1'b0;

        // load beats recovery, recovery beats a valid w
        if (load) begin
            w_y_next = load_state;
        end else if (w_y_bad) begin
            w_y_next       = S_A;
            w_illegal_next = 1'b1;
        end else if (w_valid) begin
            w_y_next = w_fsm_next;
            w_rise   = !is_ef(r_y) && is_ef(w_fsm_next);
        end
    end

    always_comb begin
        y       = r_y;
        z       = is_ef(r_y);
        illegal = r_illegal;
        z_rises = r_z_rises;
    end

endmodule
